// File: rtl/dispatch_issue_scanner.sv
// Dispatch issue scanner: sweeps the dispatch table round-robin, issues valid
// slots over a valid/ready handshake and clears each slot once it is accepted.
module dispatch_issue_scanner #(
  parameter int CORE        = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   tbl_read,
  output logic                   tbl_write,
  output logic [INDEX_WIDTH-1:0] tbl_address,
  output logic [DATA_WIDTH-1:0]  tbl_wdata,
  output logic                   tbl_wvalid,
  input  logic [DATA_WIDTH:0]    tbl_rdata,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [DATA_WIDTH-1:0]  issue_data,
  output logic [INDEX_WIDTH-1:0] issue_index,
  output logic                   sweep_empty,
  output logic [31:0]            issued_count,
  input  logic                   report
);

  typedef enum logic [1:0] {SCAN, CHECK, ISSUE, CLEAR} state_t;

  // One full sweep worth of consecutive misses means the table is empty.
  localparam logic [INDEX_WIDTH:0] MISS_LIMIT = {1'b1, {INDEX_WIDTH{1'b0}}};

  state_t                 state_reg,        state_next;
  logic [INDEX_WIDTH-1:0] ptr_reg,          ptr_next;
  logic [INDEX_WIDTH:0]   miss_cnt_reg,     miss_cnt_next;
  logic                   sweep_empty_reg,  sweep_empty_next;
  logic                   issue_valid_reg,  issue_valid_next;
  logic [DATA_WIDTH-1:0]  issue_data_reg,   issue_data_next;
  logic [INDEX_WIDTH-1:0] issue_index_reg,  issue_index_next;
  logic [31:0]            issued_count_reg, issued_count_next;
  logic                   tbl_read_reg,     tbl_read_next;
  logic                   tbl_write_reg,    tbl_write_next;
  logic [INDEX_WIDTH-1:0] tbl_address_reg,  tbl_address_next;

  logic [INDEX_WIDTH-1:0] ptr_inc;
  logic [INDEX_WIDTH-1:0] index_inc;
  logic [INDEX_WIDTH:0]   miss_cnt_inc;

  // Status printing is a simulation concern; the request strobe and core id
  // are only tied off in this synthesizable block.
  logic unused_report;
  assign unused_report = report ^ CORE[0];

  // Index arithmetic wraps naturally at the table depth.
  assign ptr_inc      = ptr_reg + 1'b1;
  assign index_inc    = issue_index_reg + 1'b1;
  assign miss_cnt_inc = (miss_cnt_reg == MISS_LIMIT) ? miss_cnt_reg : miss_cnt_reg + 1'b1;

  // State and output registers; reset drops any pending issue on the spot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= SCAN;
      ptr_reg          <= '0;
      miss_cnt_reg     <= '0;
      sweep_empty_reg  <= 1'b0;
      issue_valid_reg  <= 1'b0;
      issue_data_reg   <= '0;
      issue_index_reg  <= '0;
      issued_count_reg <= '0;
      tbl_read_reg     <= 1'b0;
      tbl_write_reg    <= 1'b0;
      tbl_address_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      miss_cnt_reg     <= miss_cnt_next;
      sweep_empty_reg  <= sweep_empty_next;
      issue_valid_reg  <= issue_valid_next;
      issue_data_reg   <= issue_data_next;
      issue_index_reg  <= issue_index_next;
      issued_count_reg <= issued_count_next;
      tbl_read_reg     <= tbl_read_next;
      tbl_write_reg    <= tbl_write_next;
      tbl_address_reg  <= tbl_address_next;
    end
  end

  // Next-state logic. Strobes are computed one cycle ahead so that the table
  // sees a registered read in SCAN and returns the entry while in CHECK.
  always_comb begin
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    miss_cnt_next     = miss_cnt_reg;
    sweep_empty_next  = sweep_empty_reg;
    issue_valid_next  = issue_valid_reg;
    issue_data_next   = issue_data_reg;
    issue_index_next  = issue_index_reg;
    issued_count_next = issued_count_reg;
    tbl_read_next     = 1'b0;
    tbl_write_next    = 1'b0;
    tbl_address_next  = tbl_address_reg;
    case (state_reg)
      SCAN: begin
        if (tbl_read_reg) begin
          // read of ptr is on the table port this cycle
          state_next = CHECK;
        end else if (enable) begin
          tbl_read_next    = 1'b1;
          tbl_address_next = ptr_reg;
        end
      end
      CHECK: begin
        if (tbl_rdata[DATA_WIDTH]) begin
          issue_data_next  = tbl_rdata[DATA_WIDTH-1:0];
          issue_index_next = ptr_reg;
          issue_valid_next = 1'b1;
          miss_cnt_next    = '0;
          sweep_empty_next = 1'b0;
          state_next       = ISSUE;
        end else begin
          ptr_next         = ptr_inc;
          miss_cnt_next    = miss_cnt_inc;
          sweep_empty_next = (miss_cnt_inc == MISS_LIMIT);
          tbl_read_next    = enable;
          tbl_address_next = ptr_inc;
          state_next       = SCAN;
        end
      end
      ISSUE: begin
        // enable is deliberately ignored: an offered entry is never withdrawn
        if (issue_ready) begin
          issued_count_next = issued_count_reg + 32'd1;
          issue_valid_next  = 1'b0;
          tbl_write_next    = 1'b1;
          tbl_address_next  = issue_index_reg;
          state_next        = CLEAR;
        end
      end
      CLEAR: begin
        ptr_next         = index_inc;
        tbl_read_next    = enable;
        tbl_address_next = index_inc;
        state_next       = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

  assign tbl_read     = tbl_read_reg;
  assign tbl_write    = tbl_write_reg;
  assign tbl_address  = tbl_address_reg;
  assign tbl_wdata    = '0;
  assign tbl_wvalid   = 1'b0;
  assign issue_valid  = issue_valid_reg;
  assign issue_data   = issue_data_reg;
  assign issue_index  = issue_index_reg;
  assign sweep_empty  = sweep_empty_reg;
  assign issued_count = issued_count_reg;

endmodule

// File: tb/tb_dispatch_issue_scanner.sv
// Bench for dispatch_issue_scanner: a bench-owned table, a slot-level model of
// what the scanner must read, issue and clear, and directed plus random runs.
module tb_dispatch_issue_scanner;
  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int DEPTH = 256;

  logic clock = 1'b0;
  logic reset, enable, issue_ready, report;
  logic tbl_read, tbl_write, tbl_wvalid, issue_valid, sweep_empty;
  logic [IW-1:0] tbl_address, issue_index;
  logic [DW-1:0] tbl_wdata, issue_data;
  logic [DW:0]   tbl_rdata;
  logic [31:0]   issued_count;

  int errors = 0;
  int checks = 0;

  // upstream writer requests, applied by the table at the next rising edge
  logic          wr_req = 1'b0, wr_clear = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [DW:0]   wr_data = '0;
  logic [DW:0]   mem [DEPTH];

  dispatch_issue_scanner #(.CORE(0), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .tbl_read(tbl_read), .tbl_write(tbl_write), .tbl_address(tbl_address),
    .tbl_wdata(tbl_wdata), .tbl_wvalid(tbl_wvalid), .tbl_rdata(tbl_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data),
    .issue_index(issue_index), .sweep_empty(sweep_empty),
    .issued_count(issued_count), .report(report)
  );

  always #5 clock = ~clock;

  // Dispatch table: registered read, scanner clears and upstream writes.
  always @(posedge clock) begin
    if (wr_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_req) begin
      mem[wr_addr] <= wr_data;
    end
    if (tbl_write) mem[tbl_address] <= {tbl_wvalid, tbl_wdata};
    if (tbl_read) tbl_rdata <= mem[tbl_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state (owned by the compare process) ----------------
  logic [DW:0]   exp_tbl [DEPTH];
  int            exp_ptr, miss_run, exp_idx;
  logic [31:0]   exp_cnt;
  bit            exp_iv;
  logic [DW-1:0] exp_data;
  bit            rd1_v, rd2_v, hs1_v, bw_v, bw_clr, prev_en, clear_armed, wrap_seen;
  int            rd1_a, rd2_a, hs1_idx, bw_a;
  logic [DW:0]   rd1_e, rd2_e, bw_d;
  int            rd_count = 0;
  int            last_rd_addr = -1;
  int            first_rd_after_clear = -1;
  int            hs_idx_q[$];
  logic [DW-1:0] hs_data_q[$];

  // Compare process: advance the slot-level model and check every cycle.
  always @(negedge clock) begin
    bit exp_wr;
    int exp_wr_a;
    if (bw_clr) begin
      for (int i = 0; i < DEPTH; i++) exp_tbl[i] = '0;
    end else if (bw_v) begin
      exp_tbl[bw_a] = bw_d;
    end
    bw_clr = wr_clear; bw_v = wr_req; bw_a = int'(wr_addr); bw_d = wr_data;
    exp_wr = 1'b0;
    exp_wr_a = 0;
    if (!reset) begin
      exp_ptr = 0; miss_run = 0; exp_cnt = '0; exp_iv = 1'b0;
      rd1_v = 1'b0; rd2_v = 1'b0; hs1_v = 1'b0; last_rd_addr = -1;
    end else begin
      // accepted last cycle: slot is being cleared now, sweep resumes after it
      if (hs1_v) begin
        exp_iv = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        exp_wr = 1'b1;
        exp_wr_a = hs1_idx;
        exp_tbl[hs1_idx] = '0;
        exp_ptr = (hs1_idx + 1) % DEPTH;
        hs1_v = 1'b0;
        clear_armed = 1'b1;
      end
      // read issued two cycles ago has been judged by now
      if (rd2_v) begin
        if (rd2_e[DW]) begin
          exp_iv = 1'b1; exp_data = rd2_e[DW-1:0]; exp_idx = rd2_a; miss_run = 0;
        end else begin
          if (miss_run < DEPTH) miss_run++;
          exp_ptr = (rd2_a + 1) % DEPTH;
        end
      end
      chk("rd_wr_exclusive", 64'(tbl_read & tbl_write), 64'd0);
      chk("wdata_zero", 64'(tbl_wdata), 64'd0);
      chk("wvalid_zero", 64'(tbl_wvalid), 64'd0);
      chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
      if (exp_iv) begin
        chk("issue_data", 64'(issue_data), 64'(exp_data));
        chk("issue_index", 64'(issue_index), 64'(exp_idx));
      end
      chk("tbl_write", 64'(tbl_write), 64'(exp_wr));
      if (exp_wr) chk("clear_addr", 64'(tbl_address), 64'(exp_wr_a));
      chk("sweep_empty", 64'(sweep_empty), 64'(miss_run >= DEPTH));
      chk("issued_count", 64'(issued_count), 64'(exp_cnt));
      if (tbl_read) begin
        chk("read_addr", 64'(tbl_address), 64'(exp_ptr));
        chk("read_enabled", 64'(prev_en), 64'd1);
        chk("read_while_busy", 64'(exp_iv | rd1_v), 64'd0);
      end
      rd2_v = rd1_v; rd2_a = rd1_a; rd2_e = rd1_e;
      rd1_v = tbl_read;
      if (tbl_read) begin
        rd1_a = int'(tbl_address);
        rd1_e = exp_tbl[tbl_address];
        rd_count++;
        if (last_rd_addr == DEPTH - 1 && tbl_address == 0) wrap_seen = 1'b1;
        last_rd_addr = int'(tbl_address);
        if (clear_armed) begin
          first_rd_after_clear = int'(tbl_address);
          clear_armed = 1'b0;
        end
      end
      if (exp_iv && issue_ready) begin
        hs1_v = 1'b1;
        hs1_idx = exp_idx;
      end
      if (issue_valid && issue_ready) begin
        hs_idx_q.push_back(int'(issue_index));
        hs_data_q.push_back(issue_data);
      end
    end
    prev_en = enable;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bench_write(input int a, input logic [DW-1:0] d);
    wr_req = 1'b1; wr_addr = IW'(a); wr_data = {1'b1, d};
    tick();
    wr_req = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int bound, input string name);
    int c = 0;
    while (hs_idx_q.size() < n && c < bound) begin tick(); c++; end
    chk(name, 64'(hs_idx_q.size() >= n), 64'd1);
  endtask

  task automatic wait_iv(input int bound, input string name);
    int c = 0;
    while (!issue_valid && c < bound) begin tick(); c++; end
    chk(name, 64'(issue_valid), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_issue_valid"}, 64'(issue_valid), 64'd0);
    chk({tag, "_tbl_read"}, 64'(tbl_read), 64'd0);
    chk({tag, "_tbl_write"}, 64'(tbl_write), 64'd0);
    chk({tag, "_tbl_address"}, 64'(tbl_address), 64'd0);
    chk({tag, "_issue_data"}, 64'(issue_data), 64'd0);
    chk({tag, "_issue_index"}, 64'(issue_index), 64'd0);
    chk({tag, "_sweep_empty"}, 64'(sweep_empty), 64'd0);
    chk({tag, "_issued_count"}, 64'(issued_count), 64'd0);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    int base, rc, c, a, last_wa;
    reset = 1'b0; enable = 1'b0; issue_ready = 1'b0; report = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    wr_clear = 1'b1;
    tick();
    wr_clear = 1'b0;
    tick();
    check_all_zero("reset");

    // empty table: no issue, wrap 255->0, sweep_empty after a full sweep
    reset = 1'b1; enable = 1'b1; issue_ready = 1'b1;
    repeat (500) tick();
    chk("s1_not_empty_yet", 64'(sweep_empty), 64'd0);
    repeat (40) tick();
    chk("s1_sweep_empty", 64'(sweep_empty), 64'd1);
    chk("s1_no_issue", 64'(issued_count), 64'd0);
    chk("s1_wrap", 64'(wrap_seen), 64'd1);

    // single valid slot issued once and cleared
    bench_write(5, 32'hDEADBEEF);
    wait_hs(1, 600, "s2_handshake");
    if (hs_idx_q.size() >= 1) begin
      chk("s2_index", 64'(hs_idx_q[0]), 64'd5);
      chk("s2_data", 64'(hs_data_q[0]), 64'hDEADBEEF);
    end
    repeat (600) tick();
    chk("s2_not_reissued", 64'(hs_idx_q.size()), 64'd1);
    chk("s2_count", 64'(issued_count), 64'd1);
    chk("s2_empty_again", 64'(sweep_empty), 64'd1);

    // two valid slots with a stalled consumer
    reset = 1'b0; enable = 1'b0; issue_ready = 1'b0;
    bench_write(3, 32'h33333333);
    bench_write(4, 32'h44444444);
    reset = 1'b1; enable = 1'b1;
    wait_iv(100, "s3_offer");
    repeat (10) begin
      chk("s3_hold_valid", 64'(issue_valid), 64'd1);
      chk("s3_hold_index", 64'(issue_index), 64'd3);
      chk("s3_hold_data", 64'(issue_data), 64'h33333333);
      tick();
    end
    base = hs_idx_q.size();
    issue_ready = 1'b1;
    wait_hs(base + 2, 100, "s3_handshakes");
    if (hs_idx_q.size() >= base + 2) begin
      chk("s3_first", 64'(hs_idx_q[base]), 64'd3);
      chk("s3_second", 64'(hs_idx_q[base+1]), 64'd4);
      chk("s3_second_data", 64'(hs_data_q[base+1]), 64'h44444444);
    end

    // last slot valid just as the sweep approaches it
    reset = 1'b0; enable = 1'b0;
    tick();
    reset = 1'b1; enable = 1'b1; issue_ready = 1'b1;
    c = 0;
    while (last_rd_addr != 253 && c < 600) begin tick(); c++; end
    chk("s4_reach_253", 64'(last_rd_addr == 253), 64'd1);
    base = hs_idx_q.size();
    bench_write(255, 32'hCAFEF00D);
    wait_hs(base + 1, 50, "s4_handshake");
    if (hs_idx_q.size() >= base + 1) begin
      chk("s4_index", 64'(hs_idx_q[base]), 64'd255);
      chk("s4_data", 64'(hs_data_q[base]), 64'hCAFEF00D);
    end
    repeat (6) tick();
    chk("s4_next_read_addr", 64'(first_rd_after_clear), 64'd0);

    // enable dropped while an entry is offered
    enable = 1'b0; issue_ready = 1'b0;
    repeat (4) tick();
    bench_write(10, 32'h0A0A0A0A);
    enable = 1'b1;
    wait_iv(600, "s5_offer");
    enable = 1'b0;
    rc = rd_count;
    base = hs_idx_q.size();
    repeat (3) tick();
    issue_ready = 1'b1;
    wait_hs(base + 1, 20, "s5_handshake");
    repeat (20) tick();
    chk("s5_no_reads", 64'(rd_count - rc), 64'd0);
    if (hs_idx_q.size() >= base + 1) chk("s5_index", 64'(hs_idx_q[base]), 64'd10);
    rc = rd_count;
    enable = 1'b1;
    repeat (10) tick();
    chk("s5_resumed", 64'(rd_count > rc), 64'd1);

    // asynchronous reset while an entry is offered
    issue_ready = 1'b0;
    bench_write(20, 32'h20202020);
    wait_iv(600, "s6_offer");
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("s6_async");
    @(posedge clock);
    #1;
    reset = 1'b1; issue_ready = 1'b1;
    base = hs_idx_q.size();
    wait_hs(base + 1, 600, "s6_reissue");
    if (hs_idx_q.size() >= base + 1) begin
      chk("s6_index", 64'(hs_idx_q[base]), 64'd20);
      chk("s6_data", 64'(hs_data_q[base]), 64'h20202020);
    end

    // randomized traffic against the model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    base = hs_idx_q.size();
    last_wa = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      enable = ($urandom_range(9) != 0);
      issue_ready = $urandom_range(1) != 0;
      wr_req = 1'b0;
      if ($urandom_range(5) == 0) begin
        a = int'($urandom_range(DEPTH - 1));
        if (exp_tbl[a][DW] == 1'b0 && a != last_wa) begin
          wr_req = 1'b1; wr_addr = IW'(a); wr_data = {1'b1, DW'($urandom)};
          last_wa = a;
        end
      end
      tick();
    end
    wr_req = 1'b0; enable = 1'b0;
    repeat (8) tick();
    chk("rand_progress", 64'(hs_idx_q.size() > base + 20), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
